// File: rtl/ntru_pkg.sv
// Shared NTRU/HRSS constants, ternary encoding and sampler state type.
// Imported by the ternary sampler and its helpers.
package ntru_pkg;

  localparam int N      = 701;
  localparam int IDX_W  = 10;
  localparam int COIN_W = 16;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_PAD,
    S_DONE
  } smp_state_t;

  function automatic logic [1:0] trit_enc(
    input logic [1:0] r
  );
    logic [1:0] t;
    t = TRIT_ZERO;
    unique case (r)
      2'd1:    t = TRIT_POS;
      2'd2:    t = TRIT_NEG;
      default: t = TRIT_ZERO;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mod3_u8.sv
// Exact 8-bit mod-3 by base-4 digit-sum folding (4 = 1 mod 3).
// Ports: val (8-bit in), rem (0..2 out). Purely combinational.
module mod3_u8 (
  input  logic [7:0] val,
  output logic [1:0] rem
);

  logic [3:0] s1;
  logic [2:0] s2;
  logic [2:0] s3;

  assign s1 = {2'b00, val[7:6]}
            + {2'b00, val[5:4]}
            + {2'b00, val[3:2]}
            + {2'b00, val[1:0]};

  assign s2 = {1'b0, s1[3:2]}
            + {1'b0, s1[1:0]};

  assign s3 = {2'b00, s2[2]}
            + {1'b0, s2[1:0]};

  always_comb begin
    rem = 2'd0;
    unique case (s3)
      3'd1:    rem = 2'd1;
      3'd2:    rem = 2'd2;
      3'd4:    rem = 2'd1;
      default: rem = 2'd0;
    endcase
  end

endmodule

// File: rtl/ternary_sampler.sv
// Turns 16-bit coin words into ternary coefficients, one per handshake.
// Ports: start/busy/done control, coin_* input stream, coef_* output stream.
module ternary_sampler #(
  parameter int N     = ntru_pkg::N,
  parameter int IDX_W = ntru_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             coin_valid,
  input  logic [15:0]      coin_data,
  output logic             coin_ready,
  output logic             coef_valid,
  output logic [1:0]       coef_data,
  output logic [IDX_W-1:0] coef_idx,
  output logic             coef_last,
  input  logic             coef_ready,
  output logic             busy,
  output logic             done
);

  import ntru_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  smp_state_t       state;
  smp_state_t       state_nx;
  logic [7:0]       hi_byte;
  logic             ptr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nx;
  logic [1:0]       trit_q;
  logic [7:0]       sel_byte;
  logic [1:0]       rem;

  assign idx_nx = idx + 1'b1;

  // One reducer: the low byte straight off the bus while fetching,
  // the buffered high byte otherwise.
  assign sel_byte = (state == S_FETCH) ? coin_data[7:0] : hi_byte;

  mod3_u8 u_mod3 (
    .val (sel_byte),
    .rem (rem)
  );

  always_comb begin
    state_nx   = state;
    coin_ready = 1'b0;
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        coin_ready = 1'b1;
        if (coin_valid) state_nx = S_EMIT;
      end
      S_EMIT: begin
        coef_valid = 1'b1;
        if (coef_ready) begin
          if (idx_nx == LAST) state_nx = S_PAD;
          else if (!ptr)      state_nx = S_EMIT;
          else                state_nx = S_FETCH;
        end
      end
      S_PAD: begin
        coef_valid = 1'b1;
        coef_last  = 1'b1;
        if (coef_ready) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      hi_byte <= 8'h00;
      ptr     <= 1'b0;
      idx     <= '0;
      trit_q  <= TRIT_ZERO;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            idx <= '0;
            ptr <= 1'b0;
          end
        end
        S_FETCH: begin
          if (coin_valid) begin
            hi_byte <= coin_data[15:8];
            ptr     <= 1'b0;
            trit_q  <= trit_enc(rem);
          end
        end
        S_EMIT: begin
          if (coef_ready) begin
            idx <= idx_nx;
            if (idx_nx == LAST) begin
              trit_q <= TRIT_ZERO;
            end else if (!ptr) begin
              ptr    <= 1'b1;
              trit_q <= trit_enc(rem);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign coef_data = trit_q;
  assign coef_idx  = idx;

endmodule

// File: tb/tb_ternary_sampler.sv
// Scoreboard bench for ternary_sampler: directed words, stalls, aborts.
// Expected coefficients are queued at issue and popped by a monitor.
module tb_ternary_sampler;

  import ntru_pkg::*;

  localparam int NW = N / 2;

  typedef struct packed {
    logic [1:0]       d;
    logic [IDX_W-1:0] i;
    logic             l;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             coin_valid = 1'b0;
  logic [15:0]      coin_data = 16'h0;
  logic             coin_ready;
  logic             coef_valid;
  logic [1:0]       coef_data;
  logic [IDX_W-1:0] coef_idx;
  logic             coef_last;
  logic             coef_ready = 1'b0;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int coin_hs = 0;
  int run_id = 0;
  int ready_pct = 100;
  bit rand_valid = 1'b0;

  logic [15:0] words[NW];
  logic [1:0]  obs[N];
  logic [1:0]  obs_a[N];
  exp_t        exp_q[$];

  ternary_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .coin_valid (coin_valid),
    .coin_data  (coin_data),
    .coin_ready (coin_ready),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_idx   (coef_idx),
    .coef_last  (coef_last),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] ref_trit(input logic [7:0] b);
    int r;
    r = int'(b) % 3;
    if (r == 0) return 2'b00;
    if (r == 1) return 2'b01;
    return 2'b11;
  endfunction

  task automatic gen_words(input bit directed);
    for (int k = 0; k < NW; k++) begin
      if (directed && k == 0) begin
        words[k] = 16'hFE01;
      end else if (directed && k <= 128) begin
        logic [7:0] v;
        v = 8'(2 * (k - 1));
        words[k] = {v + 8'd1, v};
      end else begin
        words[k] = 16'($urandom);
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < N - 1; i++) begin
      logic [15:0] w;
      w   = words[i / 2];
      e.d = ref_trit((i % 2 == 0) ? w[7:0] : w[15:8]);
      e.i = IDX_W'(i);
      e.l = 1'b0;
      exp_q.push_back(e);
    end
    e.d = 2'b00;
    e.i = IDX_W'(N - 1);
    e.l = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic run_poly(input int pct, input bit rv,
                          input int inj_at, input int abort_at);
    int  cyc;
    bit  seen_done;
    bit  injected;
    bit  prev_h1;
    ready_pct  = pct;
    rand_valid = rv;
    done_cnt   = 0;
    for (int i = 0; i < N; i++) obs[i] = 2'b10;
    push_exp();
    run_id++;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    seen_done = 1'b0;
    injected = 1'b0;
    prev_h1 = 1'b0;
    while (cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (prev_h1) chk("coin_ready_reassert", coin_ready, 1);
      prev_h1 = (pct == 100) && coef_valid && coef_ready
                && (int'(coef_idx) == 1);
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (coef_valid && int'(coef_idx) == abort_at) begin
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_coin_ready", coin_ready, 0);
        chk("rst_coef_valid", coef_valid, 0);
        chk("rst_coef_data", coef_data, 0);
        chk("rst_coef_idx", coef_idx, 0);
        chk("rst_coef_last", coef_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_cnt", done_cnt, 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        return;
      end
      if (!injected && coef_valid && int'(coef_idx) == inj_at) begin
        injected = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    chk("run_done_seen", seen_done, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("done_pulses", done_cnt, 1);
    chk("coin_handshakes", coin_hs, NW);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  // coin source
  initial begin
    int wptr;
    int my_run;
    wptr = 0;
    my_run = 0;
    forever begin
      @(negedge clk);
      if (run_id != my_run) begin
        my_run = run_id;
        wptr = 0;
        coin_hs = 0;
      end else if (rst && coin_valid && coin_ready) begin
        wptr++;
        coin_hs++;
      end
      @(posedge clk); #1;
      if (wptr < NW && (!rand_valid || $urandom_range(0, 1) == 1)) begin
        coin_valid = 1'b1;
        coin_data  = words[wptr];
      end else begin
        coin_valid = 1'b0;
        coin_data  = 16'($urandom);
      end
    end
  end

  // downstream ready
  initial begin
    forever begin
      @(posedge clk); #1;
      coef_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // monitor
  initial begin
    bit         prev_stall;
    bit         lat_pend;
    logic [1:0] st_data;
    logic [IDX_W-1:0] st_idx;
    exp_t       e;
    prev_stall = 1'b0;
    lat_pend = 1'b0;
    st_data = 2'b00;
    st_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
        lat_pend = 1'b0;
      end else begin
        if (lat_pend) chk("coef_latency", coef_valid, 1);
        lat_pend = coin_valid && coin_ready;
        chk("coin_coef_overlap", coin_ready & coef_valid, 0);
        if (prev_stall && coef_valid) begin
          chk("stall_data", coef_data, st_data);
          chk("stall_idx", coef_idx, st_idx);
        end
        prev_stall = coef_valid && !coef_ready;
        st_data = coef_data;
        st_idx = coef_idx;
        if (coef_valid && coef_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got idx %0d expected none",
                     coef_idx);
          end else begin
            e = exp_q.pop_front();
            chk("coef_data", coef_data, e.d);
            chk("coef_idx", coef_idx, e.i);
            chk("coef_last", coef_last, e.l);
          end
          if (int'(coef_idx) < N) obs[coef_idx] = coef_data;
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int diff;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_coin_ready", coin_ready, 0);
    chk("reset_coef_valid", coef_valid, 0);
    chk("reset_coef_data", coef_data, 0);
    chk("reset_coef_idx", coef_idx, 0);
    chk("reset_coef_last", coef_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(posedge clk); #1 rst = 1'b1;

    gen_words(1'b1);
    run_poly(100, 1'b0, 50, -1);
    chk("fe01_idx0", obs[0], 2'b01);
    chk("fe01_idx1", obs[1], 2'b11);
    chk("byte_00", obs[2], 2'b00);
    chk("byte_04", obs[6], 2'b01);
    chk("byte_80", obs[130], 2'b11);
    chk("byte_ff", obs[257], 2'b00);
    chk("pad_value", obs[N-1], 2'b00);
    for (int i = 0; i < N; i++) obs_a[i] = obs[i];

    run_poly(30, 1'b1, -1, -1);
    diff = 0;
    for (int i = 0; i < N; i++) if (obs[i] !== obs_a[i]) diff++;
    chk("stall_seq_diffs", diff, 0);

    gen_words(1'b0);
    run_poly(100, 1'b0, -1, 123);
    gen_words(1'b0);
    run_poly(100, 1'b0, -1, -1);
    chk("restart_idx0", obs[0], ref_trit(words[0][7:0]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ternary_sampler.md
Name: ternary_sampler

Overview:
- Consumer of the 16-bit pseudo-random coin stream produced by the random source.
- Converts coin bytes into ternary polynomial coefficients in {-1, 0, +1} (HRSS sample_iid style) and streams them out one per handshake, indexed 0..N-1.
- Sits between the random source and the polynomial memory / key-generation datapath.

Parameters:
- N, 701, polynomial length. N-1 coefficients are sampled; coefficient N-1 is forced to 0.
- COIN_W, 16, coin word width. Fixed at 16 (two bytes per word).
- IDX_W, 10, width of the coefficient index. Must satisfy 2^IDX_W >= N.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- rst, input, 1, synchronous, active-low reset (0 = reset).
- start, input, 1, one-cycle pulse that begins a polynomial. Ignored unless in IDLE.
- coin_valid, input, 1, coin word available.
- coin_data, input, 16, coin word.
- coin_ready, output, 1, sampler accepts a coin word this cycle.
- coef_valid, output, 1, coefficient output valid.
- coef_data, output, 2, encoding: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1. 2'b10 is never driven.
- coef_idx, output, IDX_W, index of the current coefficient.
- coef_last, output, 1, high with coef_valid when coef_idx == N-1.
- coef_ready, input, 1, downstream accepts the coefficient.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse after the last coefficient handshake.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE. All outputs 0 (coin_ready, coef_valid, coef_data, coef_idx, coef_last, busy, done). Word buffer and byte pointer are cleared. Reset mid-operation aborts immediately with no done pulse.
- FSM states: IDLE, FETCH, EMIT, PAD, DONE.
- IDLE:
  - start=1 -> FETCH, idx=0.
- FETCH:
  - coin_ready=1 here only.
  - On coin_valid & coin_ready: latch the word, set byte pointer to 0 (low byte), go to EMIT.
  - No timeout; the block waits indefinitely for coins.
- EMIT:
  - Coefficient is registered. coef_valid rises the cycle after the word is latched (latency 1).
  - Value: byte b = selected byte; t = b mod 3. t=0 -> 00, t=1 -> 01, t=2 -> 11.
  - coef_data/coef_idx stay stable while coef_valid=1 and coef_ready=0.
  - On handshake, idx increments, then:
    - idx_new == N-1 -> PAD.
    - else if byte pointer = 0 -> select high byte, present it next cycle.
    - else -> FETCH.
  - When N-1 is odd, the high byte of the final word is discarded.
- PAD:
  - Present coef_data=00, coef_idx=N-1, coef_last=1. No coin is consumed.
  - On handshake -> DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
- Throughput: at most one coefficient per cycle. A FETCH bubble costs one cycle per word, so sustained rate is 2 coefficients per 3 cycles.
- coin_ready is never high while coef_valid is high; the buffer holds one word.
- mod 3 on 8 bits:
  - Computed combinationally by digit-sum reduction.
  - Result must be exact for all 256 values.
  - No division operator.
- start pulses during busy=1 are ignored with no side effect.
- coef_idx wraps nowhere; the maximum value is N-1.

Decomposition:
- Shared package (ntru_pkg), holding:
  - N and IDX_W constants.
  - Ternary encoding localparams TRIT_ZERO=2'b00, TRIT_POS=2'b01, TRIT_NEG=2'b11.
  - Sampler FSM state enum typedef.
- Sub-module mod3_u8: 8-bit input, 2-bit output {0,1,2}, purely combinational, instantiated once on the selected byte.

Test Plan:
- Single word 16'hFE01, coef_ready held 1 -> idx0 = 01 (0x01 mod 3 = 1), idx1 = 11 (0xFE = 254, mod 3 = 2); coin_ready re-asserts one cycle later.
- Exhaustive mod3: 128 words covering bytes 0x00..0xFF -> each coefficient matches a reference model (e.g. 0xFF -> 00, 0x80 -> 11, 0x04 -> 01); 2'b10 never seen.
- Full run at N=701:
  - 350 random words feed 700 sampled coefficients.
  - idx 700 is 00 with coef_last=1; exactly 350 coin handshakes occur.
  - done pulses once, then busy falls.
- Backpressure: coef_ready random 30% duty, coin_valid random -> coef_data/coef_idx stable while stalled; no coin accepted while coef_valid=1; output sequence identical to the no-stall run.
- Reset mid-run: assert rst=0 at idx 123 -> next cycle all outputs 0, state IDLE, no done. A following start restarts at idx 0 with fresh coins.
- start asserted at idx 50 during a run -> ignored; run completes normally, with exactly one done pulse.
